// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
// Contents: FSM state enum, owner encodings, counter width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StResp
  } arb_state_e;

  // Owner of the transaction currently on the external bus
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Bits needed to hold the values 0 .. n-1 (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the external memory.
// Fetch port: if_req/if_addr in, if_rdata/if_ready out.
// Data port:  d_req/d_we/d_addr/d_wdata in, d_rdata/d_ready out.
// Status:     err (timed-out completion), busy (arbiter not idle).
// Memory:     mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in.
// modport master is the arbiter's view; modport slave is the environment's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              err;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready, err, busy,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready, err, busy,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_timeout_ctr.sv
// Timeout counter for an outstanding external memory request.
// Ports: clk, rst_n (async, active-low), clr_i (synchronous clear, wins over en_i),
//        en_i (count one cycle), expire_o (count has reached TIMEOUT_CYCLES-1).
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between the fetch and data requesters.
// Data has fixed priority; after STARVE_LIMIT consecutive data grants with a fetch
// waiting, the fetch wins. Requests the memory never acknowledges are aborted after
// TIMEOUT_CYCLES cycles of mem_req and completed with err=1 and zero read data.
// Ports: clk, rst_n (async, active-low), bus (mem_port_arbiter_if.master).
// All bus outputs are registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.master  bus
);

  localparam int unsigned StarveW = cnt_width(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  arb_state_e         state_q, state_d;
  logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
  logic               if_ready_q, if_ready_d;
  logic               d_ready_q, d_ready_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic in_busy;
  logic owner;
  logic expired;

  assign in_busy = (state_q == StBusyI) || (state_q == StBusyD);
  assign owner   = (state_q == StBusyD) ? OWN_D : OWN_I;

  arb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!in_busy),
    .en_i     (in_busy),
    .expire_o (expired)
  );

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.d_req && (!bus.if_req || (starve_cnt_q < StarveMax))) begin
          state_d     = StBusyD;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          // The grant guard keeps the count below StarveMax here, so +1 saturates.
          starve_cnt_d = bus.if_req ? starve_cnt_q + StarveW'(1) : '0;
        end else if (bus.if_req) begin
          state_d      = StBusyI;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = '0;
        end
      end

      StBusyI, StBusyD: begin
        if (bus.mem_ack || expired) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          err_d     = !bus.mem_ack;
          if (owner == OWN_I) begin
            if_ready_d = 1'b1;
            if_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
          end else begin
            d_ready_d = 1'b1;
            if (!bus.mem_ack) begin
              d_rdata_d = '0;
            end else if (!mem_we_q) begin
              d_rdata_d = bus.mem_rdata;
            end
          end
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scenario tasks plus a scoreboard of
// expected memory transactions and expected completions per requester.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;
  localparam int unsigned TC = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .STARVE_LIMIT   (SL),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rsp_t exp_i_q[$];
  rsp_t exp_d_q[$];
  txn_t exp_m_q[$];
  int checks = 0;
  int errors = 0;
  int ack_delay = 0;   // -1: memory never acknowledges
  bit ack_force = 1'b0;
  logic [DW-1:0] last_d_rdata = '0;

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    case (a)
      32'h10:  return 32'h0000_0013;
      32'h44:  return 32'h0000_1234;
      default: return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  function automatic txn_t mk_txn(input logic [AW-1:0] a, input logic we,
                                  input logic [DW-1:0] wd);
    txn_t t;
    t.addr = a;
    t.we = we;
    t.wdata = wd;
    return t;
  endfunction

  // Memory model: acks ack_delay cycles after mem_req rises, data from rd_val.
  task automatic responder();
    int wait_cnt = 0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (ack_delay >= 0 && wait_cnt == ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rd_val(bus.mem_addr);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      if (ack_force) bus.mem_ack = 1'b1;
    end
  endtask

  task automatic monitor();
    logic prev_req = 1'b0;
    rsp_t r;
    txn_t t;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !prev_req) begin
        checks++;
        if (exp_m_q.size() == 0) begin
          errors++;
          $display("FAIL mem_txn unexpected addr=%h we=%b", bus.mem_addr, bus.mem_we);
        end else begin
          t = exp_m_q.pop_front();
          if (bus.mem_addr !== t.addr || bus.mem_we !== t.we ||
              (t.we && bus.mem_wdata !== t.wdata)) begin
            errors++;
            $display("FAIL mem_txn got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                     bus.mem_addr, bus.mem_we, bus.mem_wdata, t.addr, t.we, t.wdata);
          end
        end
      end
      prev_req = bus.mem_req;
      if (bus.if_ready) begin
        checks++;
        if (exp_i_q.size() == 0) begin
          errors++;
          $display("FAIL if_ready unexpected rdata=%h", bus.if_rdata);
        end else begin
          r = exp_i_q.pop_front();
          if (bus.if_rdata !== r.data || bus.err !== r.err) begin
            errors++;
            $display("FAIL if_rsp got rdata=%h err=%b expected rdata=%h err=%b",
                     bus.if_rdata, bus.err, r.data, r.err);
          end
        end
      end
      if (bus.d_ready) begin
        checks++;
        if (exp_d_q.size() == 0) begin
          errors++;
          $display("FAIL d_ready unexpected rdata=%h", bus.d_rdata);
        end else begin
          r = exp_d_q.pop_front();
          if (bus.d_rdata !== r.data || bus.err !== r.err) begin
            errors++;
            $display("FAIL d_rsp got rdata=%h err=%b expected rdata=%h err=%b",
                     bus.d_rdata, bus.err, r.data, r.err);
          end
        end
      end
    end
  endtask

  // Requester drivers: called at a negedge, return at the negedge of the ready pulse.
  task automatic req_fetch(input logic [AW-1:0] a, output time done_t);
    rsp_t r;
    r.data = rd_val(a);
    r.err = 1'b0;
    exp_i_q.push_back(r);
    bus.if_req = 1'b1;
    bus.if_addr = a;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.if_ready) break;
    end
    checks++;
    if (bus.if_ready !== 1'b1) begin
      errors++;
      $display("FAIL fetch_wait addr=%h if_ready=%b expected 1", a, bus.if_ready);
    end
    done_t = $time;
    bus.if_req = 1'b0;
  endtask

  task automatic req_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic err_exp, output time done_t);
    rsp_t r;
    r.data = err_exp ? '0 : (we ? last_d_rdata : rd_val(a));
    r.err = err_exp;
    last_d_rdata = r.data;
    exp_d_q.push_back(r);
    bus.d_req = 1'b1;
    bus.d_we = we;
    bus.d_addr = a;
    bus.d_wdata = wd;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.d_ready) break;
    end
    checks++;
    if (bus.d_ready !== 1'b1) begin
      errors++;
      $display("FAIL data_wait addr=%h d_ready=%b expected 1", a, bus.d_ready);
    end
    done_t = $time;
    bus.d_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_ready, bus.d_ready,
         bus.if_rdata, bus.d_rdata, bus.err, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got mem_req=%b addr=%h busy=%b expected all zero",
               bus.mem_req, bus.mem_addr, bus.busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%b mem_req=%b expected 0 0", bus.busy, bus.mem_req);
    end
  endtask

  task automatic test_fetch_only();
    rsp_t r;
    @(negedge clk);
    ack_delay = 0;
    exp_m_q.push_back(mk_txn(32'h10, 1'b0, '0));
    r.data = 32'h13;
    r.err = 1'b0;
    exp_i_q.push_back(r);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c1 got mem_req=%b addr=%h we=%b expected 1 00000010 0",
               bus.mem_req, bus.mem_addr, bus.mem_we);
    end
    @(negedge clk);
    checks++;
    if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'h13) begin
      errors++;
      $display("FAIL fetch_c2 got if_ready=%b if_rdata=%h expected 1 00000013",
               bus.if_ready, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.if_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c3 got busy=%b if_ready=%b expected 0 0", bus.busy, bus.if_ready);
    end
  endtask

  task automatic test_simultaneous();
    time td, ti;
    @(negedge clk);
    ack_delay = 2;
    exp_m_q.push_back(mk_txn(32'h80, 1'b0, '0));
    exp_m_q.push_back(mk_txn(32'h20, 1'b0, '0));
    fork
      req_data(1'b0, 32'h80, '0, 1'b0, td);
      req_fetch(32'h20, ti);
    join
    checks++;
    if (!(td < ti)) begin
      errors++;
      $display("FAIL simul_order got d_done=%0t i_done=%0t expected data first", td, ti);
    end
  endtask

  task automatic test_starvation();
    time t0, t1;
    @(negedge clk);
    ack_delay = 0;
    for (int i = 0; i < 4; i++) exp_m_q.push_back(mk_txn(32'h100 + i, 1'b0, '0));
    exp_m_q.push_back(mk_txn(32'h200, 1'b0, '0));
    for (int i = 4; i < 8; i++) exp_m_q.push_back(mk_txn(32'h100 + i, 1'b0, '0));
    exp_m_q.push_back(mk_txn(32'h201, 1'b0, '0));
    fork
      begin
        for (int i = 0; i < 8; i++) req_data(1'b0, 32'h100 + i, '0, 1'b0, t0);
      end
      begin
        for (int i = 0; i < 2; i++) req_fetch(32'h200 + i, t1);
      end
    join
  endtask

  task automatic test_write();
    time t;
    @(negedge clk);
    ack_delay = 0;
    exp_m_q.push_back(mk_txn(32'h44, 1'b0, '0));
    req_data(1'b0, 32'h44, '0, 1'b0, t);
    exp_m_q.push_back(mk_txn(32'h40, 1'b1, 32'hDEAD_BEEF));
    req_data(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, t);
    @(negedge clk);
    checks++;
    if (bus.d_rdata !== 32'h1234) begin
      errors++;
      $display("FAIL write_rdata_hold got %h expected 00001234", bus.d_rdata);
    end
  endtask

  task automatic test_timeout();
    time t;
    int cnt;
    @(negedge clk);
    ack_delay = -1;
    exp_m_q.push_back(mk_txn(32'h60, 1'b0, '0));
    fork
      req_data(1'b0, 32'h60, '0, 1'b1, t);
      begin
        cnt = 0;
        for (int n = 0; n < 20 && !bus.mem_req; n++) @(negedge clk);
        while (bus.mem_req && cnt < 50) begin
          cnt++;
          @(negedge clk);
        end
      end
    join
    checks++;
    if (cnt != TC) begin
      errors++;
      $display("FAIL timeout_len got %0d cycles expected %0d", cnt, TC);
    end
    ack_delay = 0;
    exp_m_q.push_back(mk_txn(32'h64, 1'b0, '0));
    req_data(1'b0, 32'h64, '0, 1'b0, t);
  endtask

  task automatic test_reset_mid();
    time t;
    @(negedge clk);
    ack_delay = -1;
    exp_m_q.push_back(mk_txn(32'h90, 1'b0, '0));
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h90;
    for (int n = 0; n < 20 && !bus.mem_req; n++) @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_req got mem_req=%b expected 1", bus.mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async got mem_req=%b busy=%b expected 0 0", bus.mem_req, bus.busy);
    end
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.d_ready !== 1'b0 || bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_after got d_ready=%b busy=%b mem_req=%b expected 0 0 0",
                 bus.d_ready, bus.busy, bus.mem_req);
      end
    end
    ack_force = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    exp_m_q.push_back(mk_txn(32'h94, 1'b0, '0));
    req_data(1'b0, 32'h94, '0, 1'b0, t);
  endtask

  initial begin
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ack = 1'b0;
    fork
      responder();
      monitor();
    join_none
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_write();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_m_q.size() != 0 || exp_i_q.size() != 0 || exp_d_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got mem=%0d if=%0d d=%0d pending expected 0 0 0",
               exp_m_q.size(), exp_i_q.size(), exp_d_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one external single-port memory bus between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage core. Data requests have fixed priority, and a starvation limit guarantees fetch progress. Addresses are word-granular. A timeout aborts transactions the memory never acknowledges. Requesters see a req/ready handshake; the block sequences the external mem_req/mem_ack handshake.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending (must be >=1)
TIMEOUT_CYCLES, 255, max cycles mem_req stays high without mem_ack (must be >=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, valid when if_ready
if_ready  out  1  one-cycle completion pulse
d_req  in  1  data request, held until d_ready
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read data, valid when d_ready
d_ready  out  1  one-cycle completion pulse
err  out  1  pulses with ready when the transaction timed out
busy  out  1  high in any state except IDLE
mem_req  out  1  external request, held until mem_ack or timeout
mem_we  out  1  external write enable
mem_addr  out  ADDR_W  external address
mem_wdata  out  DATA_W  external write data
mem_rdata  in  DATA_W  external read data, valid with mem_ack
mem_ack  in  1  external completion

Interface rule: one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP. All outputs are registered.
- Reset (asynchronous, any state): state=IDLE. All outputs are 0, including if_rdata/d_rdata, mem_addr and mem_wdata. starve_cnt=0, timeout counter=0. Reset mid-transaction drops mem_req immediately. No ready pulse follows reset release.
- IDLE grant decision, evaluated each cycle:
  - d_req && (!if_req || starve_cnt < STARVE_LIMIT) -> BUSY_D.
  - else if_req -> BUSY_I.
  - else stay in IDLE.
- On grant, latch the winner's addr, we and wdata into mem_addr/mem_we/mem_wdata. Fetch grants drive mem_we=0. mem_req=1 from the next cycle (the first BUSY cycle).
- starve_cnt:
  - +1 on a data grant while if_req=1, saturating at STARVE_LIMIT.
  - Cleared on a fetch grant.
  - Cleared in IDLE when if_req=0.
- BUSY_x, mem_ack=1:
  - Capture mem_rdata into x_rdata, except on a data write, where d_rdata is unchanged.
  - mem_req=0 next cycle; go to RESP.
- BUSY_x, no ack: the timeout counter increments each BUSY cycle. If it reaches TIMEOUT_CYCLES-1 without ack, go to RESP with err_pending set and x_rdata=0. mem_req is therefore high for exactly TIMEOUT_CYCLES cycles.
- RESP: x_ready=1 for the granted owner only; err=err_pending. Next cycle, IDLE. RESP never grants, so a requester can drop or replace req the cycle after ready.
- mem_ack in IDLE or RESP is ignored.
- Changes to requester inputs while BUSY have no effect; values are latched at grant.
- Minimum latency: request seen in IDLE at cycle 0, mem_req at cycle 1, ack at cycle 1, ready at cycle 2. Next grant evaluation at cycle 3.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE/BUSY_I/BUSY_D/RESP), owner constants (OWN_I, OWN_D), and a width function for the counters (clog2).
- One sub-module, arb_timeout_ctr: clear/enable/expire counter parameterised by TIMEOUT_CYCLES.
- FSM and datapath latches stay in the top.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x10 at c0; mem_ack=1, mem_rdata=0x00000013 at c1 -> mem_req=1 with mem_addr=0x10, mem_we=0 at c1; if_ready=1, if_rdata=0x13 at c2; busy low at c3.
2. Simultaneous: if_req with addr 0x20, d_req read with addr 0x80, ack after 2 wait cycles -> first mem_addr=0x80, d_ready is the first pulse; fetch is granted at the next IDLE with mem_addr=0x20.
3. Starvation: STARVE_LIMIT=4, d_req and if_req held continuously, immediate acks -> grant order D,D,D,D,I,D...; starve_cnt returns to 0 after the fetch grant.
4. Write: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, prior d_rdata=0x1234 -> mem_we=1, mem_wdata=0xDEADBEEF; d_ready pulses; d_rdata stays 0x1234.
5. Timeout: TIMEOUT_CYCLES=8, data read, mem_ack never asserted -> mem_req high exactly 8 cycles; then d_ready=1, err=1, d_rdata=0; next request proceeds normally.
6. Reset mid BUSY_D (mem_req=1): assert rst_n=0 asynchronously -> mem_req=0 the same moment; after release, no d_ready, busy=0, a late mem_ack is ignored.
